// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: one bus entry (result plus destination tags) and the bus count.
// Reused by the ROB and reservation stations so every CDB consumer decodes the same layout.
package cdb_arbiter_pkg;

  localparam int CDB_COUNT = 2;
  localparam int CDB_XLEN  = 32;
  localparam int CDB_REG_W = 6;

  typedef struct packed {
    logic [CDB_XLEN-1:0]  result;
    logic [CDB_REG_W-1:0] arn;
    logic [CDB_REG_W-1:0] rrn;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Rotating-priority picker: first two set request bits at or above ptr (mod N), as one-hot grants.
// Latency: combinational, no state; backpressure: none, requests not granted simply stay pending.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt0,
  output logic [N-1:0]  gnt1,
  output logic          vld0,
  output logic          vld1
);

  always_comb begin
    int          idx;
    logic [PW-1:0] idx_b;
    gnt0  = '0;
    gnt1  = '0;
    vld0  = 1'b0;
    vld1  = 1'b0;
    idx   = 0;
    idx_b = '0;
    for (int j = 0; j < N; j++) begin
      idx = int'(ptr) + j;
      if (idx >= N) idx = idx - N;
      idx_b = PW'(idx);
      if (req[idx_b]) begin
        if (!vld0) begin
          gnt0[idx_b] = 1'b1;
          vld0        = 1'b1;
        end else if (!vld1) begin
          gnt1[idx_b] = 1'b1;
          vld1        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-source one-entry holding registers driven onto two CDBs by a rotating-priority picker.
// Latency: accept at edge N, earliest on CDB in cycle N+1; backpressure: src_ready low while held and ungranted.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int SOURCES = 4,
  parameter int XLEN    = CDB_XLEN,
  parameter int REG_W   = CDB_REG_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [SOURCES-1:0]         src_valid,
  output logic [SOURCES-1:0]         src_ready,
  input  logic [SOURCES*XLEN-1:0]    src_result,
  input  logic [SOURCES*REG_W-1:0]   src_arn,
  input  logic [SOURCES*REG_W-1:0]   src_rrn,
  output logic [CDB_COUNT-1:0]       cdb_valid,
  output logic [CDB_COUNT*XLEN-1:0]  cdb_result,
  output logic [CDB_COUNT*REG_W-1:0] cdb_arn,
  output logic [CDB_COUNT*REG_W-1:0] cdb_rrn
);

  localparam int PW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  cdb_entry_t           hold [SOURCES];
  logic [SOURCES-1:0]   hold_valid;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        last_idx;
  logic [PW-1:0]        next_ptr;
  logic                 ready_en;
  logic [SOURCES-1:0]   gnt0, gnt1, granted, take;
  logic                 vld0, vld1;
  logic [CDB_COUNT-1:0] bus_vld;
  cdb_entry_t           bus_ent [CDB_COUNT];

  rr_pick2 #(.N(SOURCES), .PW(PW)) u_pick (
    .req  (hold_valid),
    .ptr  (rr_ptr),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .vld0 (vld0),
    .vld1 (vld1)
  );

  // Flush suppresses every grant, so nothing is emitted or released that cycle.
  assign granted   = flush ? '0 : (gnt0 | gnt1);
  assign bus_vld   = {vld1 & ~flush, vld0 & ~flush};
  assign src_ready = {SOURCES{ready_en & ~flush}} & (~hold_valid | granted);
  assign take      = src_valid & src_ready;

  always_comb begin
    last_idx = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (vld1 ? gnt1[i] : gnt0[i]) last_idx = PW'(i);
    end
  end

  assign next_ptr = (last_idx == PW'(SOURCES - 1)) ? '0 : last_idx + 1'b1;

  always_comb begin
    bus_ent[0] = '0;
    bus_ent[1] = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (gnt0[i]) bus_ent[0] = hold[i];
      if (gnt1[i]) bus_ent[1] = hold[i];
    end
  end

  // Idle buses are all-zero and arn 0 forces a zero result: consumers match tags without looking at valid.
  always_comb begin
    cdb_valid  = '0;
    cdb_result = '0;
    cdb_arn    = '0;
    cdb_rrn    = '0;
    for (int k = 0; k < CDB_COUNT; k++) begin
      cdb_valid[k] = bus_vld[k];
      if (bus_vld[k]) begin
        cdb_arn[k*REG_W +: REG_W] = bus_ent[k].arn;
        cdb_rrn[k*REG_W +: REG_W] = bus_ent[k].rrn;
        if (bus_ent[k].arn != '0) cdb_result[k*XLEN +: XLEN] = bus_ent[k].result;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (flush)     rr_ptr <= '0;
      else if (vld0) rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= '0;
      for (int i = 0; i < SOURCES; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < SOURCES; i++) begin
        if (flush) begin
          hold_valid[i] <= 1'b0;
        end else if (take[i]) begin
          hold_valid[i]  <= 1'b1;
          hold[i].result <= src_result[i*XLEN +: XLEN];
          hold[i].arn    <= src_arn[i*REG_W +: REG_W];
          hold[i].rrn    <= src_rrn[i*REG_W +: REG_W];
        end else if (granted[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the execution units and drives them onto the two common data buses (CDB 0 and CDB 1), at most two results per cycle. Each source has a one-entry holding register with a valid/ready handshake; a rotating-priority picker grants up to two holding registers per cycle. It is the producer side of the CDB that the issue-stage operand bypass, reservation stations and ROB consume.

## Interface
- SOURCES, 4, number of result producers (ALU, branch, load/store, mul/div); legal range 2–8
- XLEN, 32, result width
- REG_W, 6, width of architectural (arn) and rename (rrn) register tags
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush on mispredict; drops all held results
- src_valid  in  SOURCES  source i offers a result
- src_ready  out  SOURCES  holding register i can accept this cycle
- src_result  in  SOURCES×XLEN  offered result
- src_arn  in  SOURCES×REG_W  destination architectural tag
- src_rrn  in  SOURCES×REG_W  destination rename tag
- cdb_valid  out  2  bus k carries a result this cycle
- cdb_result  out  2×XLEN  bus k result
- cdb_arn  out  2×REG_W  bus k architectural tag
- cdb_rrn  out  2×REG_W  bus k rename tag

## Operation
- Per source: hold_valid, hold_result, hold_arn, hold_rrn. A handshake (src_valid && src_ready) at an edge loads the holding register.
- src_ready[i] = !flush && (!hold_valid[i] || granted[i]). Same-cycle refill of a register being granted is allowed.
- Picker: scans from rr_ptr upward, modulo SOURCES. The first valid holding register goes to bus 0 and the second to bus 1.
- rr_ptr advances to (last granted index + 1) mod SOURCES. It is unchanged when nothing is granted.
- A granted register clears at the edge unless it is refilled in the same cycle.
- CDB outputs are combinational from the holding registers and the grant.
- An idle bus drives valid=0, result=0, arn=0, rrn=0. Consumers compare tags without qualifying on valid, so an idle bus must only ever match x0/tag 0 with value 0. This is mandatory.
- A bus carrying a real result with arn=0 forces result=0.
- flush=1: both buses are driven idle that cycle, every hold_valid clears at the edge, no new handshake is accepted, and rr_ptr resets to 0.
- Bus 1 is never valid while bus 0 is idle.

## Timing
- Result accepted at edge N appears on the CDB in cycle N+1 at the earliest.
- Throughput: 2 results/cycle sustained. Each source is guaranteed at most one result per cycle.
- Starvation bound: with all sources continuously valid, every source is granted within ceil(SOURCES/2) cycles.
- Reset (asynchronous assert, synchronous-safe deassert): hold_valid all 0, rr_ptr 0, src_ready all 1 after the first edge with reset_n=1 (0 while in reset), all CDB outputs 0.
- Reset mid-operation drops held results without emitting them.
- flush and src_valid in the same cycle: flush wins and the result is dropped. The source must treat ready=0 as not accepted.

## Structure
- Shared package: cdb_entry_t struct {result, arn, rrn} and the CDB_COUNT=2 constant, reused by the ROB and reservation stations.
- Sub-module rr_pick2: combinational, SOURCES request bits plus pointer in; two one-hot grants plus valid bits out; no state.
- The top level holds the holding registers, rr_ptr, the output mux and the zero-forcing.

## Test plan
- Reset: reset_n=0 mid-traffic → all cdb_* = 0 and src_ready = 0 during reset; src_ready = 1111 after release; no stale result emitted.
- Single source: src 2 offers result 0xDEAD_BEEF, arn 5, rrn 37 → next cycle cdb_valid=01 with those values on bus 0; bus 1 all zeros.
- Three simultaneous: sources 0, 1, 3 valid with rr_ptr=0 → cycle 1 buses carry src 0 and src 1; cycle 2 bus 0 carries src 3; src_ready[3]=0 during cycle 1 when no grant is pending for it.
- Fairness: all four sources continuously valid for 8 cycles → grant pairs (0,1), (2,3), (0,1)…; each source is granted exactly 4 times.
- Back-to-back refill: source 1 valid every cycle with sources 0, 2 and 3 idle → src_ready[1] stays 1 and one result per cycle appears on bus 0, in order.
- Flush: two held results plus a new offer in the flush cycle → buses idle that cycle, the offer is not accepted, and no held result ever appears afterwards; arn=0 with result 0x1234 → bus shows result 0.
